register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Parametrised successor to the single-cycle register file, for the pipelined core.
- Width, depth and read-port count are parameters; optional hardwired zero register; optional write-to-read bypass.
- Adds an asynchronous clear and a per-register busy scoreboard (reserve at issue, release at writeback, bulk flush).
- The scoreboard gives decode hazard and stall information.
- Sits between decode (reads and reservations) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high; clears all registers and busy bits
- raddr  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, combinational, packed like raddr
- rbusy  out  NUM_RD  per-port: addressed register has a pending write
- wren  in  1  writeback write enable
- waddr  in  ADDR_W  writeback address
- wdata  in  DATA_W  writeback data
- rsv_valid  in  1  request to mark rsv_addr busy
- rsv_addr  in  ADDR_W  destination being reserved
- rsv_ready  out  1  reservation will be accepted this cycle
- flush  in  1  clear all busy bits (pipeline flush); data untouched
- busy_vec  out  2**ADDR_W  registered busy bits
- busy_cnt  out  ADDR_W+1  registered count of set busy bits

Behaviour:
- Reset (async, any time, including mid-reservation): all registers = 0, busy_vec = 0, busy_cnt = 0. rdata reflects zeros combinationally; rsv_ready = 1.
- Write: on posedge with wren=1, reg[waddr] <= wdata; busy[waddr] <= 0. Ignored for waddr=0 when ZERO_REG=1.
- Read: rdata_i = reg[raddr_i], zero latency.
  - BYPASS=1 and wren and waddr==raddr_i (and not zero reg): rdata_i = wdata.
  - ZERO_REG=1 and raddr_i=0: rdata_i = 0 regardless of bypass.
- rbusy_i = busy[raddr_i], forced 0 when the bypass condition for port i holds (BYPASS=1). Always 0 for the zero register.
- rsv_ready = !busy[rsv_addr] OR (wren AND waddr==rsv_addr). Only one outstanding write per register (no WAW).
- Reservation accepted iff rsv_valid AND rsv_ready AND !flush AND !(ZERO_REG AND rsv_addr==0). Accepted reservation sets busy[rsv_addr] on posedge.
  - rsv_valid while not ready: no effect; the requester holds the request.
  - Reservation to reg 0 with ZERO_REG=1: accepted as a no-op; rsv_ready=1, busy stays 0.
- Same-edge write and accepted reservation to the same address: data written, busy ends 1 (new reservation wins).
- flush=1: busy_vec <= 0, busy_cnt <= 0 at posedge.
  - Flush overrides same-cycle reservation and write-release.
  - Same-cycle write data is still committed.
- busy_cnt tracks popcount(busy_vec) incrementally, applied in the same edge as the busy update:
  - +1 per accepted reservation that sets a clear bit.
  - −1 per write releasing a set bit that is not re-reserved.
  - Net 0 when both act on the same address.
  - Never wraps: saturation is impossible, since max = 2**ADDR_W fits in ADDR_W+1 bits.
- Writes to a non-busy register are legal (plain write, busy unchanged at 0).
- Multiple read ports may alias the same address; each is resolved independently.

Decomposition:
- Shared package regfile_pkg:
  - default DATA_W/ADDR_W constants
  - ZERO_ADDR constant
  - function for packed-port slicing
- One sub-module: regfile_scoreboard. Owns busy_vec, busy_cnt, rsv_ready and flush priority.
- The top holds the storage array, read muxes and bypass, and combines busy with bypass for rbusy.

Test Plan:
- Reset mid-operation: set busy[3], [7], then assert rst asynchronously between edges -> busy_vec=0, busy_cnt=0, rdata for raddr 3 = 0 immediately.
- Write then read: write 0xDEADBEEF to r5; next cycle raddr0=5 -> rdata0=0xDEADBEEF. Same cycle with BYPASS=1, raddr1=5 while wren -> rdata1=0xDEADBEEF combinationally.
- Zero register: wren to r0 with 0x1234, rsv_valid to r0 -> rdata for r0 = 0, busy[0]=0, busy_cnt unchanged.
- Scoreboard: reserve r9 -> rbusy=1 and rsv_ready for r9 = 0; write r9 -> busy clears. Same-edge write r9 + reserve r9 -> busy[9]=1, busy_cnt unchanged.
- Flush priority: busy r2, r4 (cnt=2); flush with rsv_valid r6 and write r2 same cycle -> busy_vec=0, cnt=0, reg[2] updated.
- Parameter sweep: NUM_RD=3, DATA_W=64, ADDR_W=4; random writes/reservations checked against a reference model. busy_cnt always equals popcount(busy_vec).

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the pipelined register file and its scoreboard.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

  // LSB of port `port` in a packed multi-port bus of `width`-bit fields
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve at issue, release at writeback, bulk flush.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wren,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic                 rsv_valid,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic                 flush,
  output logic                 rsv_ready,
  output logic [2**ADDR_W-1:0] busy_vec,
  output logic [ADDR_W:0]      busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;

  logic             wr_ok, rsv_zero, accept, inc, dec;
  logic [DEPTH-1:0] busy_nxt;

  assign wr_ok     = wren && !(ZERO_REG && waddr == ADDR_W'(ZERO_ADDR));
  assign rsv_zero  = ZERO_REG && rsv_addr == ADDR_W'(ZERO_ADDR);
  // A same-cycle writeback to the reserved register frees it in time for the new owner
  assign rsv_ready = !busy_vec[rsv_addr] || (wren && waddr == rsv_addr);
  assign accept    = rsv_valid && rsv_ready && !flush && !rsv_zero;

  assign inc = accept && !busy_vec[rsv_addr];
  assign dec = wr_ok && busy_vec[waddr] && !(accept && rsv_addr == waddr);

  always_comb begin
    busy_nxt = busy_vec;
    if (wr_ok)  busy_nxt[waddr]    = 1'b0;
    if (accept) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else if (flush) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      busy_vec <= busy_nxt;
      busy_cnt <= busy_cnt + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
    end
  end
endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with optional zero register, write bypass and busy scoreboard.
module register_file_sb import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     wren,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ready,
  input  logic                     flush,
  output logic [2**ADDR_W-1:0]     busy_vec,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  assign wr_ok = wren && !(ZERO_REG && waddr == ADDR_W'(ZERO_ADDR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wren      (wren),
    .waddr     (waddr),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .rsv_ready (rsv_ready),
    .busy_vec  (busy_vec),
    .busy_cnt  (busy_cnt)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero, byp;
    assign ra      = raddr[port_lsb(i, ADDR_W) +: ADDR_W];
    assign is_zero = ZERO_REG && ra == ADDR_W'(ZERO_ADDR);
    assign byp     = BYPASS && wren && waddr == ra && !is_zero;
    assign rdata[port_lsb(i, DATA_W) +: DATA_W] = is_zero ? '0 : byp ? wdata : mem[ra];
    // Forwarded data is the pending result, so the hazard is already resolved
    assign rbusy[i] = busy_vec[ra] && !byp && !is_zero;
  end
endmodule

// File: tb/tb_register_file_sb.sv
// Randomized and directed check of register_file_sb against a behavioural model.
module tb_register_file_sb;
  localparam int DW = 64, AW = 4, NR = 3, DEPTH = 16;

  logic              clk = 1'b0, rst;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic              wren, rsv_valid, rsv_ready, flush;
  logic [AW-1:0]     waddr, rsv_addr;
  logic [DW-1:0]     wdata;
  logic [DEPTH-1:0]  busy_vec;
  logic [AW:0]       busy_cnt;

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] m_reg [DEPTH];
  bit            m_busy [DEPTH];

  register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wren(wren), .waddr(waddr), .wdata(wdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .flush(flush), .busy_vec(busy_vec), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int r = 0; r < DEPTH; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  function automatic logic [DEPTH-1:0] m_vec();
    logic [DEPTH-1:0] v = '0;
    for (int r = 0; r < DEPTH; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic bit m_ready();
    return !m_busy[rsv_addr] || (wren && waddr == rsv_addr);
  endfunction

  task automatic m_reset();
    for (int r = 0; r < DEPTH; r++) begin m_reg[r] = '0; m_busy[r] = 1'b0; end
  endtask

  // Applies the edge rules to the model using the inputs held across the edge
  task automatic m_edge();
    bit acc;
    acc = rsv_valid && m_ready() && !flush && rsv_addr != 0;
    if (wren && waddr != 0) m_reg[waddr] = wdata;
    if (flush) for (int r = 0; r < DEPTH; r++) m_busy[r] = 1'b0;
    else begin
      if (wren && waddr != 0) m_busy[waddr] = 1'b0;
      if (acc) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  task automatic check_comb();
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    bit            b;
    for (int p = 0; p < NR; p++) begin
      a = raddr[p*AW +: AW];
      if (a == 0)                    e = '0;
      else if (wren && waddr == a)   e = wdata;
      else                           e = m_reg[a];
      b = (a != 0) && m_busy[a] && !(wren && waddr == a);
      chk($sformatf("rdata%0d", p), rdata[p*DW +: DW], e);
      chk($sformatf("rbusy%0d", p), 64'(rbusy[p]), 64'(b));
    end
    chk("rsv_ready", 64'(rsv_ready), 64'(m_ready()));
  endtask

  task automatic check_seq();
    chk("busy_vec", 64'(busy_vec), 64'(m_vec()));
    chk("busy_cnt", 64'(busy_cnt), 64'(m_cnt()));
  endtask

  // Called just after a negedge: check comb outputs, clock once, check state
  task automatic cycle();
    #1 check_comb();
    @(posedge clk);
    m_edge();
    #1 check_seq();
    @(negedge clk);
  endtask

  task automatic drv(input bit we, input int wa, input logic [DW-1:0] wd,
                     input bit rv, input int ra, input bit fl);
    wren = we; waddr = AW'(wa); wdata = wd;
    rsv_valid = rv; rsv_addr = AW'(ra); flush = fl;
  endtask

  task automatic set_rd(input int p, input int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    rst = 1'b1; raddr = '0;
    drv(0, 0, '0, 0, 0, 0);
    m_reset();
    #2;
    chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("rst_busy_cnt", 64'(busy_cnt), 64'h0);
    chk("rst_ready", 64'(rsv_ready), 64'h1);
    chk("rst_rdata", rdata[DW-1:0], 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Write then read, plus same-cycle bypass on port 1
    set_rd(1, 5);
    drv(1, 5, 64'hDEADBEEF, 0, 0, 0);
    #1 chk("bypass", rdata[DW +: DW], 64'hDEADBEEF);
    cycle();
    set_rd(0, 5); set_rd(1, 0);
    drv(0, 0, '0, 0, 0, 0);
    #1 chk("wr_rd", rdata[DW-1:0], 64'hDEADBEEF);
    cycle();

    // Zero register ignores write and reservation
    set_rd(0, 0);
    drv(1, 0, 64'h1234, 1, 0, 0);
    #1 chk("zero_ready", 64'(rsv_ready), 64'h1);
    cycle();
    chk("zero_busy", 64'(busy_vec[0]), 64'h0);
    chk("zero_cnt", 64'(busy_cnt), 64'h0);
    chk("zero_rdata", rdata[DW-1:0], 64'h0);

    // Scoreboard reserve / release / same-edge re-reserve
    drv(0, 0, '0, 1, 9, 0);
    cycle();
    set_rd(0, 9);
    drv(0, 0, '0, 0, 9, 0);
    #1 chk("r9_rbusy", 64'(rbusy[0]), 64'h1);
    chk("r9_ready", 64'(rsv_ready), 64'h0);
    cycle();
    drv(1, 9, 64'h99, 0, 0, 0);
    cycle();
    chk("r9_release", 64'(busy_vec[9]), 64'h0);
    drv(0, 0, '0, 1, 9, 0);
    cycle();
    drv(1, 9, 64'h999, 1, 9, 0);
    cycle();
    chk("r9_rersv_busy", 64'(busy_vec[9]), 64'h1);
    chk("r9_rersv_cnt", 64'(busy_cnt), 64'h1);

    // Flush beats reservation and release; write data still lands
    drv(0, 0, '0, 1, 2, 0); cycle();
    drv(0, 0, '0, 1, 4, 0); cycle();
    drv(1, 2, 64'h2222_0000_AAAA, 1, 6, 1);
    cycle();
    chk("flush_vec", 64'(busy_vec), 64'h0);
    chk("flush_cnt", 64'(busy_cnt), 64'h0);
    set_rd(2, 2);
    drv(0, 0, '0, 0, 0, 0);
    #1 chk("flush_data", rdata[2*DW +: DW], 64'h2222_0000_AAAA);
    cycle();

    // Random sweep against the model
    for (int n = 0; n < 600; n++) begin
      int wa;
      wa = int'($urandom_range(0, DEPTH-1));
      drv(($urandom % 2) == 0, wa, {$urandom, $urandom}, ($urandom % 3) != 0,
          int'($urandom_range(0, DEPTH-1)), ($urandom % 25) == 0);
      for (int p = 0; p < NR; p++)
        set_rd(p, (($urandom % 4) == 0) ? wa : int'($urandom_range(0, DEPTH-1)));
      cycle();
    end

    // Asynchronous reset between edges with reservations outstanding
    set_rd(0, 3);
    drv(1, 3, 64'h3333, 0, 0, 0); cycle();
    drv(0, 0, '0, 1, 3, 0); cycle();
    drv(0, 0, '0, 1, 7, 0); cycle();
    drv(0, 0, '0, 0, 0, 0);
    #2 rst = 1'b1;
    m_reset();
    #1;
    chk("arst_vec", 64'(busy_vec), 64'h0);
    chk("arst_cnt", 64'(busy_cnt), 64'h0);
    chk("arst_rdata", rdata[DW-1:0], 64'h0);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
